// File: rtl/shift_exec_stage_pkg.sv
// Shared definitions for the shift execute stage: datapath widths and the
// R-type funct codes handled by SHIFT32.
package shift_exec_stage_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;

  typedef enum logic [5:0] {
    FN_SLL  = 6'h01,
    FN_SRL  = 6'h02,
    FN_SLLV = 6'h03,
    FN_SRLV = 6'h04
  } funct_e;

endpackage

// File: rtl/shift32.sv
// SHIFT32: combinational 32-bit logical shifter.
//   Y   out 32  shifted result
//   D   in  32  data to shift
//   S   in  32  shift amount; any value >= 32 yields zero
//   LnR in  1   1 = shift left, 0 = shift right (logical)
module SHIFT32 (
  output logic [31:0] Y,
  input  logic [31:0] D,
  input  logic [31:0] S,
  input  logic        LnR
);

  always_comb begin
    if (|S[31:5]) Y = '0;
    else if (LnR) Y = D << S[4:0];
    else          Y = D >> S[4:0];
  end

endmodule

// File: rtl/shift_result_fifo.sv
// shift_result_fifo: synchronous FIFO buffering shift results for writeback.
//   clk, rst  clock / synchronous active-high reset
//   wr_en     push wdata (ignored when full without a same-cycle pop)
//   rd_en     pop head (ignored when empty)
//   rdata     head entry; while empty, the last entry that was at the head
//   full/empty derived from the occupancy count
module shift_result_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] last_q;
  logic             push, pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign pop   = rd_en & ~empty;
  assign push  = wr_en & (~full | pop);

  // When empty the output keeps showing the most recent head entry.
  assign rdata = empty ? last_q : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (!empty) last_q <= mem[rd_ptr];
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/shift_exec_stage.sv
// shift_exec_stage: execute-stage wrapper around SHIFT32.
//   CLK, RST                 clock / synchronous active-high reset
//   in_valid/in_ready        upstream handshake for decoded shift ops
//   in_funct/shamt/rs/rt/tag op fields from register-file read
//   out_valid/out_ready      downstream handshake toward writeback
//   out_result/tag/zero      FIFO head result, its tag, result==0 flag
//   illegal_op               one-cycle pulse after an unsupported funct is consumed
module shift_exec_stage
  import shift_exec_stage_pkg::*;
#(
  parameter int unsigned TAG_W      = 5,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_funct,
  input  logic [4:0]        in_shamt,
  input  logic [31:0]       in_rs,
  input  logic [31:0]       in_rt,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_zero,
  output logic              illegal_op
);

  logic              s1_valid;
  logic [DATA_W-1:0] s1_d, s1_s;
  logic              s1_lnr;
  logic [TAG_W-1:0]  s1_tag;

  logic              dec_legal, dec_lnr;
  logic [DATA_W-1:0] dec_s;
  logic [DATA_W-1:0] shift_y;

  logic              fifo_full, fifo_empty;
  logic [DATA_W+TAG_W-1:0] fifo_rdata;
  logic              pop, s1_advance, accept;

  always_comb begin
    dec_legal = 1'b0;
    dec_lnr   = 1'b0;
    dec_s     = '0;
    case (in_funct)
      FN_SLL:  begin dec_legal = 1'b1; dec_lnr = 1'b1; dec_s = {{(DATA_W-SHAMT_W){1'b0}}, in_shamt}; end
      FN_SRL:  begin dec_legal = 1'b1; dec_lnr = 1'b0; dec_s = {{(DATA_W-SHAMT_W){1'b0}}, in_shamt}; end
      FN_SLLV: begin dec_legal = 1'b1; dec_lnr = 1'b1; dec_s = in_rt; end
      FN_SRLV: begin dec_legal = 1'b1; dec_lnr = 1'b0; dec_s = in_rt; end
      default: ;
    endcase
  end

  // S1 may drain into a full FIFO only when the head leaves on the same edge.
  assign out_valid  = ~fifo_empty;
  assign pop        = out_valid & out_ready;
  assign s1_advance = s1_valid & (~fifo_full | pop);
  assign in_ready   = ~s1_valid | s1_advance;
  assign accept     = in_valid & in_ready;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_valid   <= 1'b0;
      s1_d       <= '0;
      s1_s       <= '0;
      s1_lnr     <= 1'b0;
      s1_tag     <= '0;
      illegal_op <= 1'b0;
    end else begin
      illegal_op <= accept & ~dec_legal;
      if (accept && dec_legal) begin
        s1_valid <= 1'b1;
        s1_d     <= in_rs;
        s1_s     <= dec_s;
        s1_lnr   <= dec_lnr;
        s1_tag   <= in_tag;
      end else if (s1_advance) begin
        s1_valid <= 1'b0;
      end
    end
  end

  SHIFT32 u_shift (
    .Y   (shift_y),
    .D   (s1_d),
    .S   (s1_s),
    .LnR (s1_lnr)
  );

  shift_result_fifo #(
    .WIDTH (DATA_W + TAG_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .wr_en (s1_advance),
    .wdata ({shift_y, s1_tag}),
    .rd_en (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign {out_result, out_tag} = fifo_rdata;
  assign out_zero = (out_result == '0);

endmodule

// File: tb/tb_shift_exec_stage.sv
module tb_shift_exec_stage;

  localparam int unsigned TAG_W = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [5:0]        in_funct = '0;
  logic [4:0]        in_shamt = '0;
  logic [31:0]       in_rs = '0;
  logic [31:0]       in_rt = '0;
  logic [TAG_W-1:0]  in_tag = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [31:0]       out_result;
  logic [TAG_W-1:0]  out_tag;
  logic              out_zero;
  logic              illegal_op;

  always #5 clk = ~clk;

  shift_exec_stage #(.TAG_W(TAG_W), .FIFO_DEPTH(2)) dut (
    .CLK(clk), .RST(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct(in_funct),
    .in_shamt(in_shamt), .in_rs(in_rs), .in_rt(in_rt), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_zero(out_zero), .illegal_op(illegal_op)
  );

  int n_vec = 0;
  int n_err = 0;

  // Expected results in issue order: {result, tag}
  logic [32+TAG_W-1:0] exp_q[$];
  logic exp_ill = 1'b0;
  int   n_acc = 0, n_pop = 0;
  logic last_ir, last_ov;
  logic [31:0] last_res;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: shift amount taken literally; 32 or more empties the word.
  function automatic logic [31:0] ref_shift(input logic [5:0] f, input logic [4:0] sh,
                                            input logic [31:0] rs, input logic [31:0] rt);
    longint unsigned amt, v, p;
    bit left;
    amt  = (f == 6'h01 || f == 6'h02) ? longint'(sh) : longint'(rt);
    left = (f == 6'h01 || f == 6'h03);
    if (amt >= 32) return 32'h0;
    v = longint'(rs);
    p = 64'd1 << amt;
    return left ? 32'(v * p) : 32'(v / p);
  endfunction

  task automatic step(input logic v, input logic [5:0] f, input logic [4:0] sh,
                      input logic [31:0] rs, input logic [31:0] rt,
                      input logic [TAG_W-1:0] tg, input logic ordy);
    logic [32+TAG_W-1:0] e;
    logic legal;
    @(negedge clk);
    in_valid = v; in_funct = f; in_shamt = sh; in_rs = rs; in_rt = rt;
    in_tag = tg; out_ready = ordy;
    #1;
    last_ir = in_ready; last_ov = out_valid; last_res = out_result;
    exp_ill = 1'b0;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() == 0) check_eq("idle_valid", 32'(out_valid), 32'd0);
      if (out_valid && out_ready) begin
        n_pop++;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("result", out_result, e[32+TAG_W-1:TAG_W]);
          check_eq("tag", 32'(out_tag), 32'(e[TAG_W-1:0]));
          check_eq("zero", 32'(out_zero), 32'(e[32+TAG_W-1:TAG_W] == 32'h0));
        end
      end
      if (in_valid && in_ready) begin
        n_acc++;
        legal = (f >= 6'h01 && f <= 6'h04);
        if (legal) exp_q.push_back({ref_shift(f, sh, rs, rt), tg});
        else exp_ill = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check_eq("illegal_op", 32'(illegal_op), 32'(exp_ill));
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 6'h00, 5'd0, 32'h0, 32'h0, '0, ordy);
  endtask

  int a0, p0;
  logic [5:0] rf;

  initial begin
    // Reset for two cycles
    rst = 1'b1;
    idle(1'b0);
    idle(1'b0);
    rst = 1'b0;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_illegal", 32'(illegal_op), 32'd0);
    check_eq("rst_out_zero", 32'(out_zero), 32'd1);
    check_eq("rst_out_result", out_result, 32'h0);
    check_eq("rst_out_tag", 32'(out_tag), 32'd0);

    // SLL by 31, latency check
    step(1'b1, 6'h01, 5'd31, 32'h0000_0001, 32'h0, 5'd3, 1'b1);
    idle(1'b1);
    check_eq("lat_not_yet", 32'(last_ov), 32'd0);
    idle(1'b1);
    check_eq("lat_valid", 32'(last_ov), 32'd1);
    check_eq("sll31", last_res, 32'h8000_0000);

    // SRLV by 40 and by 4
    step(1'b1, 6'h04, 5'd0, 32'hFFFF_FFFF, 32'd40, 5'd4, 1'b1);
    step(1'b1, 6'h04, 5'd0, 32'hFFFF_FFFF, 32'd4, 5'd5, 1'b1);
    idle(1'b1);
    check_eq("srlv40", last_res, 32'h0);
    idle(1'b1);
    check_eq("srlv4", last_res, 32'h0FFF_FFFF);
    idle(1'b1);

    // Backpressure: 4 SLLs with out_ready low
    a0 = n_acc;
    for (int i = 0; i < 4; i++)
      step(1'b1, 6'h01, 5'(i + 1), 32'h0000_0003, 32'h0, 5'(10 + i), 1'b0);
    check_eq("bp_accepted", 32'(n_acc - a0), 32'd3);
    check_eq("bp_in_ready", 32'(last_ir), 32'd0);
    p0 = n_pop;
    for (int i = 0; i < 3; i++) idle(1'b1);
    check_eq("bp_drain", 32'(n_pop - p0), 32'd3);
    idle(1'b1);

    // Streaming: 8 back-to-back ops
    a0 = n_acc; p0 = n_pop;
    for (int i = 0; i < 8; i++)
      step(1'b1, 6'(1 + (i % 4)), 5'(i * 3), 32'hA5A5_0F0F + 32'(i), 32'(i * 5), 5'(20 + i), 1'b1);
    idle(1'b1);
    idle(1'b1);
    check_eq("stream_acc", 32'(n_acc - a0), 32'd8);
    check_eq("stream_pop", 32'(n_pop - p0), 32'd8);

    // Illegal funct
    step(1'b1, 6'h20, 5'd1, 32'h1234_5678, 32'h0, 5'd7, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Reset with FIFO holding two entries
    step(1'b1, 6'h01, 5'd1, 32'h1, 32'h0, 5'd1, 1'b0);
    step(1'b1, 6'h02, 5'd1, 32'h8, 32'h0, 5'd2, 1'b0);
    idle(1'b0);
    check_eq("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    idle(1'b0);
    rst = 1'b0;
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 4; i++) idle(1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rf = ($urandom_range(0, 9) < 9) ? 6'($urandom_range(1, 4)) : 6'($urandom_range(5, 63));
      step(($urandom_range(0, 9) < 7), rf, 5'($urandom_range(0, 31)), $urandom,
           ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom,
           5'($urandom), ($urandom_range(0, 9) < 6));
    end
    for (int i = 0; i < 30 && exp_q.size() > 0; i++) idle(1'b1);
    check_eq("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
